// File: rtl/evaluator_arb_pkg.sv
// Shared types and defaults for the evaluator arbiter: FSM state encoding,
// parameter defaults and the timeout counter width helper.
package evaluator_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESPOND   = 2'd3
    } arb_state_e;

    localparam int N_REQ_DEF   = 4;
    localparam int W_DEF       = 8;
    localparam int TIMEOUT_DEF = 255;

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate the request vector so ptr sits at
// bit 0, priority-encode the lowest set bit, then un-rotate back to an index.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [IW-1:0]    idx_o,
    output logic             valid_o
);

    logic [N_REQ-1:0] rot_s;
    logic [IW-1:0]    off_s;
    logic [IW:0]      sum_s;

    // Rotate, encode and un-rotate in one combinational pass.
    always_comb begin
        rot_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                rot_s[i] = rot_s[i] | ((ptr_i == IW'(j)) & req_i[(i + j) % N_REQ]);
            end
        end

        // Scanning high to low lets the lowest set offset overwrite the rest.
        off_s = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? IW'(i) : off_s;
        end

        sum_s   = {1'b0, off_s} + {1'b0, ptr_i};
        idx_o   = (sum_s >= (IW + 1)'(N_REQ)) ? IW'(sum_s - (IW + 1)'(N_REQ))
                                              : sum_s[IW-1:0];
        valid_o = |req_i;
    end

endmodule

// File: rtl/evaluator_arbiter.sv
// Round-robin arbiter sharing one multi-cycle sqrt(a^2+b^2) evaluator between
// N_REQ requesters, with a per-job timeout that returns an error response.
module evaluator_arbiter
    import evaluator_arb_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [N_REQ*W-1:0] a_bi,
    input  logic [N_REQ*W-1:0] b_bi,
    output logic [N_REQ-1:0]   ack_o,
    output logic [N_REQ-1:0]   done_o,
    output logic [W-1:0]       y_bo,
    output logic               err_o,
    output logic               ev_start_o,
    output logic [W-1:0]       ev_a_bo,
    output logic [W-1:0]       ev_b_bo,
    input  logic               ev_busy_i,
    input  logic [W-1:0]       ev_y_bi
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = cnt_width(TIMEOUT);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              err_q, err_d;
    logic              start_q, start_d;
    logic [W-1:0]      y_q, y_d;

    logic [IW-1:0]     pick_idx_s;
    logic              pick_valid_s;
    logic [W-1:0]      sel_a_s;
    logic [W-1:0]      sel_b_s;
    logic              expired_s;

    function automatic logic [N_REQ-1:0] to_onehot(input logic [IW-1:0] k);
        return {{(N_REQ-1){1'b0}}, 1'b1} << k;
    endfunction

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx_s),
        .valid_o (pick_valid_s)
    );

    // AND-OR mux of the winner's operands out of the packed buses.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sel_a_s = sel_a_s | ({W{pick_idx_s == IW'(k)}} & a_bi[k*W +: W]);
            sel_b_s = sel_b_s | ({W{pick_idx_s == IW'(k)}} & b_bi[k*W +: W]);
        end
    end

    assign expired_s = (cnt_q == CW'(TIMEOUT));

    // Next-state and registered-output logic for the arbitration FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
        start_d = start_q;
        y_d     = y_q;

        case (state_q)
            IDLE: begin
                // A busy evaluator here is left over from an aborted job.
                if (pick_valid_s && !ev_busy_i) begin
                    idx_d   = pick_idx_s;
                    a_d     = sel_a_s;
                    b_d     = sel_b_s;
                    cnt_d   = '0;
                    ack_d   = to_onehot(pick_idx_s);
                    start_d = 1'b1;
                    state_d = ISSUE;
                end else begin
                    start_d = 1'b0;
                end
            end
            ISSUE: begin
                if (expired_s) begin
                    y_d     = '0;
                    err_d   = 1'b1;
                    done_d  = to_onehot(idx_q);
                    start_d = 1'b0;
                    state_d = RESPOND;
                end else if (ev_busy_i) begin
                    cnt_d   = cnt_q + CW'(1);
                    start_d = 1'b0;
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (expired_s) begin
                    y_d     = '0;
                    err_d   = 1'b1;
                    done_d  = to_onehot(idx_q);
                    start_d = 1'b0;
                    state_d = RESPOND;
                end else if (!ev_busy_i) begin
                    y_d     = ev_y_bi;
                    done_d  = to_onehot(idx_q);
                    state_d = RESPOND;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            RESPOND: begin
                ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);
                start_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                start_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            y_q     <= y_d;
        end
    end

    assign ack_o      = ack_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign y_bo       = y_q;
    assign ev_start_o = start_q;
    assign ev_a_bo    = a_q;
    assign ev_b_bo    = b_q;

endmodule

// File: tb/tb_evaluator_arbiter.sv
// Scoreboard bench for evaluator_arbiter with a behavioural evaluator model
// (stub and forced-busy modes) and per-done result checking.
module tb_evaluator_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;
    localparam int EV_LAT = 5;

    typedef struct {
        int idx;
        int y;
        int err;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [N-1:0]     req_i;
    logic [N*W-1:0]   a_bi;
    logic [N*W-1:0]   b_bi;
    logic [N-1:0]     ack_o;
    logic [N-1:0]     done_o;
    logic [W-1:0]     y_bo;
    logic             err_o;
    logic             ev_start_o;
    logic [W-1:0]     ev_a_bo;
    logic [W-1:0]     ev_b_bo;
    logic             ev_busy_i;
    logic [W-1:0]     ev_y_bi;

    logic             stub_mode;
    logic             force_busy;
    logic             ev_busy_m;
    logic [3:0]       ev_cnt_m;
    logic [W-1:0]     ev_y_m;

    int               n_chk = 0;
    int               n_err = 0;
    exp_t             sb_q[$];
    exp_t             mon_e;

    evaluator_arbiter #(
        .N_REQ   (N),
        .W       (W),
        .TIMEOUT (TO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .a_bi       (a_bi),
        .b_bi       (b_bi),
        .ack_o      (ack_o),
        .done_o     (done_o),
        .y_bo       (y_bo),
        .err_o      (err_o),
        .ev_start_o (ev_start_o),
        .ev_a_bo    (ev_a_bo),
        .ev_b_bo    (ev_b_bo),
        .ev_busy_i  (ev_busy_i),
        .ev_y_bi    (ev_y_bi)
    );

    always #5 clk_i = ~clk_i;

    function automatic int isqrt(input int s);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    function automatic logic [N-1:0] oh(input int k);
        logic [N-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Behavioural evaluator: busy for EV_LAT+1 cycles after accepting start.
    always @(posedge clk_i) begin
        if (rst_i) begin
            ev_busy_m <= 1'b0;
            ev_cnt_m  <= 4'd0;
            ev_y_m    <= '0;
        end else if (stub_mode) begin
            ev_busy_m <= 1'b0;
        end else if (!ev_busy_m && ev_start_o) begin
            ev_busy_m <= 1'b1;
            ev_cnt_m  <= 4'(EV_LAT);
            ev_y_m    <= 8'(isqrt(int'(ev_a_bo) * int'(ev_a_bo) + int'(ev_b_bo) * int'(ev_b_bo)));
        end else if (ev_busy_m) begin
            if (ev_cnt_m == 4'd0) ev_busy_m <= 1'b0;
            else                  ev_cnt_m  <= ev_cnt_m - 4'd1;
        end
    end

    assign ev_busy_i = ev_busy_m | force_busy;
    assign ev_y_bi   = ev_y_m;

    // Scoreboard monitor on the falling edge.
    always @(negedge clk_i) begin
        if (!rst_i && ack_o != '0) begin
            check_eq("ack_onehot", 32'($countones(ack_o)), 32'd1);
        end
        if (!rst_i && done_o != '0) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_done", 32'(done_o), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("done_idx", 32'(done_o), 32'(oh(mon_e.idx)));
                check_eq("y", 32'(y_bo), 32'(mon_e.y));
                check_eq("err", 32'(err_o), 32'(mon_e.err));
                check_eq("start_low_at_done", 32'(ev_start_o), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_ops(input int k, input int a, input int b);
        a_bi[k*W +: W] = 8'(a);
        b_bi[k*W +: W] = 8'(b);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_o == '0 && n < 200) begin
            tick();
            n++;
        end
        if (done_o == '0) check_eq("done_within_bound", 32'(done_o != '0), 32'd1);
    endtask

    task automatic single_job(input int k, input int a, input int b);
        sb_q.push_back('{idx: k, y: isqrt(a * a + b * b), err: 0});
        set_ops(k, a, b);
        req_i[k] = 1'b1;
        tick();
        check_eq("ack_latency", 32'(ack_o), 32'(oh(k)));
        req_i[k] = 1'b0;
        wait_done();
        tick();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        int order [8];
        int left [N];
        int grants;
        int guard;
        int kk;
        int n;

        rst_i = 1'b1; req_i = '0; a_bi = '0; b_bi = '0;
        stub_mode = 1'b0; force_busy = 1'b0;
        tick();
        tick();
        check_eq("rst_ack", 32'(ack_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_start", 32'(ev_start_o), 32'd0);
        check_eq("rst_y", 32'(y_bo), 32'd0);
        rst_i = 1'b0;
        tick();

        // Single requester jobs.
        single_job(0, 3, 4);
        single_job(0, 5, 12);
        single_job(0, 8, 15);

        // Simultaneous requests from ptr=0, then prove ptr landed on 3.
        do_reset();
        sb_q.push_back('{idx: 0, y: 13, err: 0});
        sb_q.push_back('{idx: 2, y: 77, err: 0});
        set_ops(0, 5, 12);
        set_ops(2, 55, 55);
        req_i = 4'b0101;
        tick();
        check_eq("sim_ack0", 32'(ack_o), 32'(oh(0)));
        req_i[0] = 1'b0;
        wait_done();
        tick();
        tick();
        check_eq("sim_ack2", 32'(ack_o), 32'(oh(2)));
        req_i[2] = 1'b0;
        wait_done();
        tick();
        sb_q.push_back('{idx: 3, y: 10, err: 0});
        set_ops(0, 1, 1);
        set_ops(3, 6, 8);
        req_i = 4'b1001;
        tick();
        check_eq("ptr_at_3", 32'(ack_o), 32'(oh(3)));
        req_i = 4'b0001;
        wait_done();
        req_i = '0;
        tick();
        check_eq("sb_empty_sim", 32'(sb_q.size()), 32'd0);
        do_reset();

        // All four held continuously for 8 jobs.
        order = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int k = 0; k < N; k++) begin
            left[k] = 2;
            set_ops(k, 3 * k + 5 * left[k] + 2, 4 * k + 3 * left[k] + 1);
        end
        req_i = 4'b1111;
        grants = 0;
        guard = 0;
        while (grants < 8 && guard < 600) begin
            tick();
            guard++;
            if (ack_o != '0) begin
                check_eq("rr_order", 32'(ack_o), 32'(oh(order[grants])));
                kk = 0;
                for (int i = 0; i < N; i++) if (ack_o[i]) kk = i;
                sb_q.push_back('{idx: kk,
                                 y: isqrt(int'(a_bi[kk*W +: W]) * int'(a_bi[kk*W +: W]) +
                                          int'(b_bi[kk*W +: W]) * int'(b_bi[kk*W +: W])),
                                 err: 0});
                req_i[kk] = 1'b0;
                left[kk]--;
                grants++;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!req_i[k] && left[k] > 0) begin
                        set_ops(k, 3 * k + 5 * left[k] + 2, 4 * k + 3 * left[k] + 1);
                        req_i[k] = 1'b1;
                    end
                end
            end
        end
        check_eq("rr_grants", 32'(grants), 32'd8);
        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            tick();
            guard++;
        end
        check_eq("rr_all_done", 32'(sb_q.size()), 32'd0);
        tick();

        // Evaluator that never raises busy: timeout path.
        stub_mode = 1'b1;
        sb_q.push_back('{idx: 1, y: 0, err: 1});
        set_ops(1, 3, 4);
        req_i[1] = 1'b1;
        tick();
        check_eq("to_ack", 32'(ack_o), 32'(oh(1)));
        req_i[1] = 1'b0;
        n = 0;
        while (done_o == '0 && n < 60) begin
            tick();
            n++;
        end
        check_eq("to_latency", 32'(n), 32'(TO + 1));
        check_eq("to_err", 32'(err_o), 32'd1);
        tick();
        check_eq("to_start_low", 32'(ev_start_o), 32'd0);
        stub_mode = 1'b0;
        tick();

        // Busy already high in IDLE blocks the grant.
        force_busy = 1'b1;
        sb_q.push_back('{idx: 0, y: 10, err: 0});
        set_ops(0, 6, 8);
        req_i[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("no_ack_while_busy", 32'(ack_o), 32'd0);
        end
        force_busy = 1'b0;
        tick();
        check_eq("ack_after_busy", 32'(ack_o), 32'(oh(0)));
        req_i[0] = 1'b0;
        wait_done();
        tick();

        // Reset in WAIT_DONE abandons the job.
        set_ops(2, 3, 4);
        req_i[2] = 1'b1;
        tick();
        check_eq("rw_ack", 32'(ack_o), 32'(oh(2)));
        req_i[2] = 1'b0;
        n = 0;
        while (ev_start_o && n < 20) begin
            tick();
            n++;
        end
        check_eq("rw_in_wait", 32'(ev_start_o), 32'd0);
        rst_i = 1'b1;
        tick();
        check_eq("rw_ack0", 32'(ack_o), 32'd0);
        check_eq("rw_done0", 32'(done_o), 32'd0);
        check_eq("rw_err0", 32'(err_o), 32'd0);
        check_eq("rw_start0", 32'(ev_start_o), 32'd0);
        check_eq("rw_y0", 32'(y_bo), 32'd0);
        check_eq("rw_ea0", 32'(ev_a_bo), 32'd0);
        check_eq("rw_eb0", 32'(ev_b_bo), 32'd0);
        rst_i = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 12; i++) tick();
        single_job(1, 1, 5);
        check_eq("sb_empty_end", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/evaluator_arbiter.md
Name: evaluator_arbiter

Overview:
- Shares one multi-cycle `evaluator` between N_REQ requesters. The evaluator computes y = sqrt(a^2 + b^2), e.g. 3,4 -> 5.
- Grants requesters round-robin, latches the winner's operands and drives the evaluator's start/operand inputs.
- Waits on the evaluator's busy handshake, then returns the result to the winner with a done pulse.
- Instantiated between requesting blocks and the single `evaluator` instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 8, operand/result width
TIMEOUT, 255, max cycles in ISSUE+WAIT_DONE before abort (>=2)

Ports:
clk_i  in  1  single clock, all logic on posedge
rst_i  in  1  synchronous, active-high reset
req_i  in  N_REQ  per-requester request level; held with stable operands until ack
a_bi  in  N_REQ*W  operand a, requester k at [k*W +: W]
b_bi  in  N_REQ*W  operand b, same packing
ack_o  out  N_REQ  one-cycle pulse: operands captured for requester k
done_o  out  N_REQ  one-cycle pulse: y_bo/err_o valid for requester k
y_bo  out  W  result, valid only in the done_o cycle, held otherwise
err_o  out  1  pulses with done_o when the job timed out
ev_start_o  out  1  to evaluator start_i
ev_a_bo  out  W  to evaluator a_bi
ev_b_bo  out  W  to evaluator b_bi
ev_busy_i  in  1  from evaluator busy_o
ev_y_bi  in  W  from evaluator y_bo

Behaviour:
- Reset (sync, rst_i=1 at posedge):
  - state=IDLE, ptr=0.
  - ack_o, done_o, err_o, ev_start_o all 0.
  - y_bo, ev_a_bo, ev_b_bo all 0.
  - timeout counter 0.
  - A reset mid-operation abandons the job: no done_o is issued. The evaluator is reset by the same rst_i.
- IDLE:
  - At a posedge with |req_i && !ev_busy_i, pick the winner: the first set bit scanning from ptr upward, wrapping modulo N_REQ.
  - Latch idx, a, b. Go to ISSUE.
  - If ev_busy_i=1 (leftover from an aborted job), no grant is made.
- ISSUE:
  - ev_start_o=1; ev_a_bo/ev_b_bo hold the latched operands.
  - ack_o[idx]=1 in the first ISSUE cycle only.
  - ev_start_o stays high until ev_busy_i=1 is sampled, then go to WAIT_DONE; ev_start_o=0 from the next cycle.
- WAIT_DONE:
  - On the first posedge with ev_busy_i=0, register y_bo<=ev_y_bi and go to RESPOND.
- RESPOND (one cycle):
  - done_o[idx]=1, err_o=0.
  - ptr <= (idx+1) mod N_REQ.
  - Next state is IDLE.
- Timeout:
  - The counter clears on entering ISSUE and increments each cycle in ISSUE/WAIT_DONE.
  - When it reaches TIMEOUT, go to RESPOND with y_bo<=0, err_o=1, done_o[idx]=1, ev_start_o<=0.
  - ptr advances as normal.
- Requester contract:
  - Drop req_i no later than the done_o cycle.
  - A req_i still high in IDLE is treated as a new request.
- Latency:
  - req_i sampled at edge k gives ack_o in cycle k+1.
  - done_o comes 2 cycles after the evaluator's busy falls, counted from the cycle busy is sampled low.
  - Minimum overhead is 3 cycles plus the evaluator's compute time.
- Invariants:
  - At most one bit of ack_o and done_o is set.
  - ev_start_o is never high outside ISSUE.
  - Latched operands are stable from ISSUE through RESPOND.
- Simultaneous requests: only the round-robin winner is served; the others wait, keeping req_i high.

Decomposition:
- Package `evaluator_arb_pkg`:
  - State encoding IDLE/ISSUE/WAIT_DONE/RESPOND.
  - Defaults for W, N_REQ and TIMEOUT.
  - Counter width = clog2(TIMEOUT+1).
- Sub-module `rr_pick` (combinational):
  - Inputs req vector and ptr; outputs winner index and valid.
  - Implemented as rotate, priority-encode, un-rotate.

Test Plan:
- Single requester 0 with a=3, b=4 -> one ack_o[0] pulse; later y_bo=5 with done_o[0] pulse, err_o=0. Repeat with (5,12)->13 and (8,15)->17.
- req_i=4'b0101 at the same time, ptr=0: (0:5,12), (2:55,55) -> requester 0 done with y=13, then requester 2 done with y=77; ptr ends at 3.
- All four held continuously for 8 jobs -> grant order 0,1,2,3,0,1,2,3; no requester starves.
- Stub evaluator never raises busy, TIMEOUT=16, req 1 -> done_o[1] with err_o=1 and y_bo=0, 17 cycles after ack; ev_start_o then low.
- ev_busy_i forced high in IDLE with req 0 -> no ack_o until busy drops, then a normal grant.
- rst_i asserted in WAIT_DONE -> the next cycle has all outputs 0 and state IDLE; no done_o; a fresh (1,5)->5 job completes correctly.
